// File: rtl/pipelined_icache_ctrl_pkg.sv
// Shared types for the pipelined instruction-cache controller.
package pipelined_icache_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS,
        ST_FLUSH
    } state_t;

    localparam logic ADDR_CPU  = 1'b0;
    localparam logic ADDR_PREV = 1'b1;

endpackage

// File: rtl/pipelined_icache_ctrl_plru_tree.sv
// Tree-PLRU victim selection and hit update for one set.
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-1:0] i_valid,
    input  logic [WAYS-2:0] i_lru,
    input  logic [WAYS-1:0] i_hit_way,
    output logic [WAYS-1:0] o_victim,
    output logic [WAYS-2:0] o_lru_new
);

    localparam int LVL = $clog2(WAYS);

    always_comb begin : victim_sel
        logic           found;
        logic           b;
        logic [LVL-1:0] way;
        logic [LVL:0]   node;
        found = 1'b0;
        b     = 1'b0;
        way   = '0;
        node  = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!found && !i_valid[i]) begin
                found = 1'b1;
                way   = i[LVL-1:0];
            end
        end
        if (!found) begin
            for (int l = 0; l < LVL; l++) begin
                b = 1'b0;
                for (int n = 0; n < WAYS-1; n++) begin
                    if (node == (LVL+1)'(n)) b = i_lru[n];
                end
                way[LVL-1-l] = b;
                node = {node[LVL-1:0], 1'b1} + (LVL+1)'(b);
            end
        end
        o_victim      = '0;
        o_victim[way] = 1'b1;
    end

    // Each node on the hit path is made to point at the other subtree.
    always_comb begin : lru_upd
        logic           b;
        logic [LVL-1:0] hidx;
        logic [LVL:0]   node;
        hidx = '0;
        node = '0;
        b    = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (i_hit_way[i]) hidx = hidx | i[LVL-1:0];
        end
        o_lru_new = i_lru;
        for (int l = 0; l < LVL; l++) begin
            b = hidx[LVL-1-l];
            for (int n = 0; n < WAYS-1; n++) begin
                if (node == (LVL+1)'(n)) o_lru_new[n] = ~b;
            end
            node = {node[LVL-1:0], 1'b1} + (LVL+1)'(b);
        end
    end

endmodule

// File: rtl/pipelined_icache_ctrl.sv
// Instruction-cache control FSM: hit/miss sequencing, line fill and flush walk.
module pipelined_icache_ctrl
    import pipelined_icache_ctrl_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    output logic             mem_resp,
    input  logic             flush,
    output logic             flush_done,
    output logic             pmem_read,
    input  logic             pmem_resp,
    input  logic [WAYS-1:0]  s2_hit_way,
    input  logic [WAYS-1:0]  s2_valid,
    input  logic [WAYS-2:0]  s2_lru,
    output logic [WAYS-1:0]  fill_way,
    output logic             valid_datain,
    output logic             lru_load,
    output logic [WAYS-2:0]  lru_datain,
    output logic             addr_sel,
    output logic [IDX_W-1:0] flush_idx,
    output logic             flush_active
);

    localparam int              SETS = 2**IDX_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(SETS-1);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_flush_idx;
    logic             r_flush_pend;
    logic             r_drop;
    logic             r_flush_done;
    logic             w_hit;
    logic [WAYS-1:0]  w_victim;
    logic [WAYS-2:0]  w_lru_new;

    assign w_hit      = |s2_hit_way;
    assign flush_done = r_flush_done;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .i_valid   (s2_valid),
        .i_lru     (s2_lru),
        .i_hit_way (s2_hit_way),
        .o_victim  (w_victim),
        .o_lru_new (w_lru_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_flush_idx  <= '0;
            r_flush_pend <= 1'b0;
            r_drop       <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_flush_done <= (r_state == ST_FLUSH) && (r_flush_idx == LAST);
            if (r_state == ST_FLUSH)
                r_flush_idx <= (r_flush_idx == LAST) ? '0 : r_flush_idx + IDX_W'(1);
            if (w_next == ST_FLUSH)
                r_flush_pend <= 1'b0;
            else if (r_state == ST_MISS && flush)
                r_flush_pend <= 1'b1;
            // Remembers an abandoned fetch so the fill ends without a replay.
            r_drop <= (r_state == ST_MISS) && (r_drop || !mem_read);
        end
    end

    always_comb begin
        w_next       = r_state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        fill_way     = '0;
        valid_datain = 1'b0;
        lru_load     = 1'b0;
        lru_datain   = '0;
        addr_sel     = ADDR_CPU;
        flush_idx    = '0;
        flush_active = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (flush)
                    w_next = ST_FLUSH;
                else if (mem_read)
                    w_next = w_hit ? ST_LOOKUP : ST_MISS;
            end
            ST_LOOKUP: begin
                if (mem_read && w_hit) begin
                    mem_resp   = 1'b1;
                    lru_load   = 1'b1;
                    lru_datain = w_lru_new;
                end
                if (flush)
                    w_next = ST_FLUSH;
                else if (!mem_read)
                    w_next = ST_IDLE;
                else if (!w_hit)
                    w_next = ST_MISS;
            end
            ST_MISS: begin
                addr_sel  = ADDR_PREV;
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill_way     = w_victim;
                    valid_datain = 1'b1;
                    if (flush || r_flush_pend)
                        w_next = ST_FLUSH;
                    else if (r_drop || !mem_read)
                        w_next = ST_IDLE;
                    else
                        w_next = ST_LOOKUP;
                end
            end
            ST_FLUSH: begin
                flush_active = 1'b1;
                fill_way     = '1;
                flush_idx    = r_flush_idx;
                if (r_flush_idx == LAST)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pipelined_icache_ctrl.sv
// Directed + randomized bench for pipelined_icache_ctrl with a PLRU reference model.
module tb_pipelined_icache_ctrl;

    localparam int WAYS  = 4;
    localparam int IDX_W = 3;
    localparam int SETS  = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read;
    logic       flush;
    logic       pmem_resp;
    logic [3:0] s2_hit_way;
    logic [3:0] s2_valid;
    logic [2:0] s2_lru;
    logic       mem_resp;
    logic       flush_done;
    logic       pmem_read;
    logic [3:0] fill_way;
    logic       valid_datain;
    logic       lru_load;
    logic [2:0] lru_datain;
    logic       addr_sel;
    logic [2:0] flush_idx;
    logic       flush_active;
    logic [16:0] outs;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    pipelined_icache_ctrl #(.WAYS(WAYS), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_resp     (mem_resp),
        .flush        (flush),
        .flush_done   (flush_done),
        .pmem_read    (pmem_read),
        .pmem_resp    (pmem_resp),
        .s2_hit_way   (s2_hit_way),
        .s2_valid     (s2_valid),
        .s2_lru       (s2_lru),
        .fill_way     (fill_way),
        .valid_datain (valid_datain),
        .lru_load     (lru_load),
        .lru_datain   (lru_datain),
        .addr_sel     (addr_sel),
        .flush_idx    (flush_idx),
        .flush_active (flush_active)
    );

    assign outs = {mem_resp, flush_done, pmem_read, fill_way, valid_datain,
                   lru_load, lru_datain, addr_sel, flush_idx, flush_active};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Victim: first invalid way, else root bit picks half, child bit picks way.
    function automatic int ref_victim(input logic [3:0] v, input logic [2:0] l);
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        if (l[0]) return l[2] ? 3 : 2;
        return l[1] ? 1 : 0;
    endfunction

    function automatic logic [2:0] ref_upd(input logic [2:0] l, input int w);
        logic [2:0] r;
        r = l;
        r[0] = (w < 2);
        if (w < 2) r[1] = (w == 0);
        else       r[2] = (w == 2);
        return r;
    endfunction

    task automatic check_idle();
        tick();
        rst = 0; flush = 0; pmem_resp = 0;
        mem_read = 1; s2_hit_way = 4'b0010; s2_lru = 3'b000; s2_valid = 4'hF;
        #1;
        chk("idle_no_resp", mem_resp, 0);
        tick(); #1;
        chk("lookup_resp", mem_resp, 1);
        chk("lookup_lru", lru_datain, ref_upd(3'b000, 1));
        tick(); mem_read = 0; s2_hit_way = 0; #1;
        chk("lookup_release", outs, 0);
    endtask

    task automatic flush_walk(input bit rst3);
        for (int k = 0; k < SETS; k++) begin
            tick();
            mem_read = 0; flush = 0; s2_hit_way = 0; pmem_resp = 0; rst = 0;
            #1;
            chk("flush_active", flush_active, 1);
            chk("flush_idx", flush_idx, k);
            chk("flush_fill_way", fill_way, 4'hF);
            chk("flush_vdin", valid_datain, 0);
            chk("flush_quiet", {mem_resp, pmem_read, flush_done}, 0);
            if (rst3 && k == 2) begin
                rst = 1;
                break;
            end
        end
        if (rst3) begin
            tick(); rst = 0; #1;
            chk("rst_flush_outs", outs, 0);
            check_idle();
        end else begin
            tick(); #1;
            chk("flush_done", flush_done, 1);
            chk("flush_done_active", flush_active, 0);
            tick(); #1;
            chk("flush_done_pulse", flush_done, 0);
        end
    endtask

    task automatic do_miss(input logic [3:0] v, input logic [2:0] l, input int lat,
                           input bit drop, input bit fl);
        int vw;
        vw = ref_victim(v, l);
        tick();
        mem_read = 1; flush = 0; s2_hit_way = 0; s2_valid = v; s2_lru = l; pmem_resp = 0;
        #1;
        chk("miss_idle_resp", mem_resp, 0);
        for (int c = 1; c <= lat; c++) begin
            tick();
            pmem_resp = (c == lat);
            flush = fl && (c == 1);
            if (drop) mem_read = 0;
            #1;
            chk("miss_pmem_read", pmem_read, 1);
            chk("miss_addr_sel", addr_sel, 1);
            chk("miss_resp", mem_resp, 0);
            chk("miss_fill_way", fill_way, (c == lat) ? (32'd1 << vw) : 32'd0);
            chk("miss_vdin", valid_datain, c == lat);
            chk("miss_lru_load", lru_load, 0);
        end
        if (fl) begin
            flush_walk(0);
        end else if (drop) begin
            check_idle();
        end else begin
            tick();
            flush = 0; pmem_resp = 0; s2_hit_way = 4'(1 << vw);
            #1;
            chk("replay_resp", mem_resp, 1);
            chk("replay_lru_load", lru_load, 1);
            chk("replay_lru", lru_datain, ref_upd(l, vw));
            chk("replay_addr_sel", addr_sel, 0);
            tick(); mem_read = 0; s2_hit_way = 0; #1;
            chk("replay_release", outs, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        logic [2:0] l;
        rst = 1; mem_read = 0; flush = 0; pmem_resp = 0;
        s2_hit_way = 0; s2_valid = 0; s2_lru = 0;
        repeat (3) tick();
        rst = 0; #1;
        chk("reset_outs", outs, 0);

        tick(); flush = 1; #1;
        chk("flush_req_idle", outs, 0);
        flush_walk(0);

        do_miss(4'hF, 3'b000, 5, 0, 0);
        do_miss(4'b1011, 3'($urandom), 3, 0, 0);

        // way 2: root points low (0), node 2 points to way 3 (1), node 1 kept
        tick(); mem_read = 1; s2_hit_way = 4'b0100; s2_lru = 3'b111; s2_valid = 4'hF; #1;
        chk("hit_w2_idle", mem_resp, 0);
        tick(); #1;
        chk("hit_w2_resp", mem_resp, 1);
        chk("hit_w2_lru", lru_datain, 3'b110);
        tick(); mem_read = 0; s2_hit_way = 0; #1;
        chk("hit_w2_release", outs, 0);

        tick(); mem_read = 1; s2_hit_way = 4'b0001; #1;
        chk("b2b_idle", mem_resp, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            w = $urandom_range(0, 3);
            l = 3'($urandom);
            s2_hit_way = 4'(1 << w); s2_lru = l; flush = (i == 19);
            #1;
            chk("b2b_resp", mem_resp, 1);
            chk("b2b_lru_load", lru_load, 1);
            chk("b2b_lru", lru_datain, ref_upd(l, w));
        end
        flush_walk(0);

        for (int i = 0; i < 12; i++)
            do_miss(4'($urandom), 3'($urandom), $urandom_range(1, 6), 0, 0);

        do_miss(4'($urandom), 3'($urandom), 4, 1, 0);
        do_miss(4'hF, 3'($urandom), 3, 0, 1);

        tick(); flush = 1; mem_read = 1; s2_hit_way = 4'b0001; #1;
        chk("flush_prio_resp", mem_resp, 0);
        flush_walk(0);

        tick(); flush = 1; #1;
        flush_walk(1);
        tick(); flush = 1; #1;
        flush_walk(0);

        tick(); mem_read = 1; s2_hit_way = 0; s2_valid = 4'hF; #1;
        tick(); flush = 1; #1;
        chk("rst_fill_pmem", pmem_read, 1);
        tick(); flush = 0; rst = 1; #1;
        tick(); rst = 0; mem_read = 0; #1;
        chk("rst_fill_outs", outs, 0);
        check_idle();
        do_miss(4'hF, 3'b101, 2, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
